// File: rtl/meas_result_arbiter.sv
// meas_result_arbiter: per-channel measurement result slots drained round-robin onto one valid/ready stream
// clk, reset                       clock, synchronous active-high reset
// done, resultx, resulty           per-channel result strobe and discrimination bits
// xacc, yacc                       per-channel accumulators, ch i at [i*ACCW+:ACCW]
// out_valid, out_ready             output handshake
// out_ch .. out_tstamp             registered output word
// pending, overflow                slot-occupied and sticky overflow flags
// clear_overflow                   clears all overflow flags
module meas_result_arbiter #(
    parameter int NCH = 4,
    parameter int ACCW = 32,
    parameter int TSW = 32,
    localparam int CHW = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCH-1:0]      done,
    input  logic [NCH-1:0]      resultx,
    input  logic [NCH-1:0]      resulty,
    input  logic [ACCW*NCH-1:0] xacc,
    input  logic [ACCW*NCH-1:0] yacc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHW-1:0]      out_ch,
    output logic                out_resultx,
    output logic                out_resulty,
    output logic [ACCW-1:0]     out_xacc,
    output logic [ACCW-1:0]     out_yacc,
    output logic [TSW-1:0]      out_tstamp,
    output logic [NCH-1:0]      pending,
    output logic [NCH-1:0]      overflow,
    input  logic                clear_overflow
);
    logic [TSW-1:0]  ts;
    logic [CHW-1:0]  ptr, g;
    logic [NCH-1:0]  sx, sy, drain, take, lost;
    logic [ACCW-1:0] sxa [NCH];
    logic [ACCW-1:0] sya [NCH];
    logic [TSW-1:0]  sts [NCH];
    logic            load;

    assign load = (!out_valid || out_ready) && |pending;

    // scan from the farthest candidate down so the nearest pending slot after ptr wins
    always_comb begin
        g = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (pending[(int'(ptr) + k) % NCH]) g = CHW'((int'(ptr) + k) % NCH);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        assign drain[i] = load && g == CHW'(i);
        assign take[i]  = done[i] && (!pending[i] || drain[i]);
        assign lost[i]  = done[i] && pending[i] && !drain[i];
        always_ff @(posedge clk) begin
            if (reset) pending[i] <= 1'b0;
            else pending[i] <= take[i] || (pending[i] && !drain[i]);
            if (take[i]) begin
                sx[i]  <= resultx[i];
                sy[i]  <= resulty[i];
                sxa[i] <= xacc[i*ACCW +: ACCW];
                sya[i] <= yacc[i*ACCW +: ACCW];
                sts[i] <= ts;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts          <= '0;
            ptr         <= CHW'(NCH - 1);
            overflow    <= '0;
            out_valid   <= 1'b0;
            out_ch      <= '0;
            out_resultx <= 1'b0;
            out_resulty <= 1'b0;
            out_xacc    <= '0;
            out_yacc    <= '0;
            out_tstamp  <= '0;
        end else begin
            ts       <= ts + 1'b1;
            overflow <= (clear_overflow ? '0 : overflow) | lost;
            if (load) begin
                out_valid   <= 1'b1;
                ptr         <= g;
                out_ch      <= g;
                out_resultx <= sx[g];
                out_resulty <= sy[g];
                out_xacc    <= sxa[g];
                out_yacc    <= sya[g];
                out_tstamp  <= sts[g];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_meas_result_arbiter.sv
// tb_meas_result_arbiter: directed checks of capture, round-robin drain, overflow, hold, wrap and reset
module tb_meas_result_arbiter;
    localparam int NCH = 4;
    localparam int ACCW = 32;
    localparam int TSW = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NCH-1:0]      done = '0;
    logic [NCH-1:0]      resultx = 4'b1010;
    logic [NCH-1:0]      resulty = 4'b0110;
    logic [ACCW*NCH-1:0] xacc = {32'hCAFE_0003, 32'h0000_1234, 32'hCAFE_0001, 32'hCAFE_0000};
    logic [ACCW*NCH-1:0] yacc = {32'hBEEF_0003, 32'hBEEF_0002, 32'hBEEF_0001, 32'hBEEF_0000};
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [1:0]          out_ch;
    logic                out_resultx, out_resulty;
    logic [ACCW-1:0]     out_xacc, out_yacc;
    logic [TSW-1:0]      out_tstamp;
    logic [NCH-1:0]      pending, overflow;
    logic                clear_overflow = 1'b0;
    logic [TSW-1:0]      cyc;
    int                  total = 0;
    int                  bad = 0;

    meas_result_arbiter #(.NCH(NCH), .ACCW(ACCW), .TSW(TSW)) dut (
        .clk(clk), .reset(reset), .done(done), .resultx(resultx), .resulty(resulty),
        .xacc(xacc), .yacc(yacc), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_resultx(out_resultx), .out_resulty(out_resulty),
        .out_xacc(out_xacc), .out_yacc(out_yacc), .out_tstamp(out_tstamp),
        .pending(pending), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= reset ? '0 : cyc + 1'b1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        done = '0;
        clear_overflow = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0 || overflow !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags: valid=%b pending=%b overflow=%b want 0/0000/0000", out_valid, pending, overflow);
        end
        total++;
        if (out_ch !== 2'd0 || out_xacc !== 32'd0 || out_yacc !== 32'd0 || out_tstamp !== 8'd0 || out_resultx !== 1'b0 || out_resulty !== 1'b0) begin
            bad++;
            $display("FAIL reset_word: ch=%0d x=%h y=%h ts=%0d rx=%b ry=%b want all 0", out_ch, out_xacc, out_yacc, out_tstamp, out_resultx, out_resulty);
        end
    endtask

    task automatic test_single;
        do_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        done = 4'b0100;
        tick;
        done = '0;
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0100) begin
            bad++;
            $display("FAIL single_c11: valid=%b pending=%b want 0/0100", out_valid, pending);
        end
        tick;
        total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_xacc !== 32'h1234 || out_tstamp !== 8'd10) begin
            bad++;
            $display("FAIL single_word: valid=%b ch=%0d x=%h ts=%0d want 1/2/00001234/10", out_valid, out_ch, out_xacc, out_tstamp);
        end
        tick;
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0) begin
            bad++;
            $display("FAIL single_once: valid=%b pending=%b want 0/0000", out_valid, pending);
        end
    endtask

    task automatic test_back_to_back;
        logic [TSW-1:0] t;
        logic [31:0] ex [4];
        ex[0] = 32'hCAFE_0000; ex[1] = 32'hCAFE_0001; ex[2] = 32'h0000_1234; ex[3] = 32'hCAFE_0003;
        do_reset;
        out_ready = 1'b1;
        tick;
        t = cyc;
        done = 4'b1111;
        tick;
        done = '0;
        tick;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_ch !== 2'(i) || out_xacc !== ex[i] || out_yacc !== (32'hBEEF_0000 | i) || out_tstamp !== t
                || out_resultx !== resultx[i] || out_resulty !== resulty[i]) begin
                bad++;
                $display("FAIL b2b_word%0d: valid=%b ch=%0d x=%h y=%h ts=%0d rx=%b ry=%b want ch=%0d x=%h ts=%0d",
                    i, out_valid, out_ch, out_xacc, out_yacc, out_tstamp, out_resultx, out_resulty, i, ex[i], t);
            end
            tick;
        end
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0 || overflow !== 4'b0) begin
            bad++;
            $display("FAIL b2b_end: valid=%b pending=%b overflow=%b want 0/0000/0000", out_valid, pending, overflow);
        end
    endtask

    task automatic test_overflow;
        logic [TSW-1:0] t1;
        do_reset;
        done = 4'b0001;
        tick;
        done = '0;
        tick;
        t1 = cyc;
        done = 4'b0010;
        tick;
        done = '0;
        for (int i = 0; i < 4; i++) tick;
        done = 4'b0010;
        tick;
        done = '0;
        total++;
        if (overflow !== 4'b0010 || pending !== 4'b0010 || out_ch !== 2'd0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: overflow=%b pending=%b ch=%0d valid=%b want 0010/0010/0/1", overflow, pending, out_ch, out_valid);
        end
        tick;
        total++;
        if (overflow !== 4'b0010) begin
            bad++;
            $display("FAIL ovf_sticky: overflow=%b want 0010", overflow);
        end
        clear_overflow = 1'b1;
        done = 4'b0010;
        tick;
        done = '0;
        total++;
        if (overflow !== 4'b0010) begin
            bad++;
            $display("FAIL ovf_event_wins: overflow=%b want 0010", overflow);
        end
        tick;
        clear_overflow = 1'b0;
        total++;
        if (overflow !== 4'b0000) begin
            bad++;
            $display("FAIL ovf_clear: overflow=%b want 0000", overflow);
        end
        out_ready = 1'b1;
        tick;
        total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_tstamp !== t1 || out_xacc !== 32'hCAFE_0001) begin
            bad++;
            $display("FAIL ovf_first_kept: valid=%b ch=%0d ts=%0d x=%h want 1/1/%0d/cafe0001", out_valid, out_ch, out_tstamp, out_xacc, t1);
        end
        tick;
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0) begin
            bad++;
            $display("FAIL ovf_drained: valid=%b pending=%b want 0/0000", out_valid, pending);
        end
    endtask

    task automatic test_hold;
        logic [TSW-1:0] t;
        int errs;
        do_reset;
        t = cyc;
        done = 4'b0101;
        tick;
        done = '0;
        tick;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_xacc !== 32'hCAFE_0000 || out_yacc !== 32'hBEEF_0000
                || out_tstamp !== t || out_resultx !== 1'b0 || out_resulty !== 1'b0 || pending !== 4'b0100) begin
                bad++;
                if (errs++ == 0)
                    $display("FAIL hold_stable@%0d: valid=%b ch=%0d x=%h y=%h ts=%0d pending=%b want 1/0/cafe0000/beef0000/%0d/0100",
                        i, out_valid, out_ch, out_xacc, out_yacc, out_tstamp, pending, t);
            end
            tick;
        end
        out_ready = 1'b1;
        tick;
        total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_xacc !== 32'h1234 || out_tstamp !== t || out_resultx !== 1'b0 || out_resulty !== 1'b1) begin
            bad++;
            $display("FAIL hold_next: valid=%b ch=%0d x=%h ts=%0d rx=%b ry=%b want 1/2/00001234/%0d/0/1",
                out_valid, out_ch, out_xacc, out_tstamp, out_resultx, out_resulty, t);
        end
        tick;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_end: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_wrap;
        do_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 255; i++) tick;
        done = 4'b1000;
        tick;
        done = 4'b1000;
        tick;
        done = '0;
        total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_tstamp !== 8'd255) begin
            bad++;
            $display("FAIL wrap_255: valid=%b ch=%0d ts=%0d want 1/3/255", out_valid, out_ch, out_tstamp);
        end
        tick;
        total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_tstamp !== 8'd0 || overflow !== 4'b0) begin
            bad++;
            $display("FAIL wrap_0: valid=%b ch=%0d ts=%0d overflow=%b want 1/3/0/0000", out_valid, out_ch, out_tstamp, overflow);
        end
        tick;
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0) begin
            bad++;
            $display("FAIL wrap_end: valid=%b pending=%b want 0/0000", out_valid, pending);
        end
    endtask

    task automatic test_mid_reset;
        do_reset;
        done = 4'b1111;
        tick;
        done = '0;
        tick;
        total++;
        if (out_valid !== 1'b1 || pending !== 4'b1110) begin
            bad++;
            $display("FAIL mreset_setup: valid=%b pending=%b want 1/1110", out_valid, pending);
        end
        reset = 1'b1;
        done = 4'b0010;
        tick;
        reset = 1'b0;
        done = '0;
        total++;
        if (out_valid !== 1'b0 || pending !== 4'b0 || out_ch !== 2'd0 || out_xacc !== 32'd0) begin
            bad++;
            $display("FAIL mreset_clear: valid=%b pending=%b ch=%0d x=%h want 0/0000/0/0", out_valid, pending, out_ch, out_xacc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if (out_valid !== 1'b0 || pending !== 4'b0) begin
                bad++;
                $display("FAIL mreset_stale%0d: valid=%b pending=%b want 0/0000", i, out_valid, pending);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_hold;
        test_wrap;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
